// File: rtl/mem_loader_pkg.sv
// Shared types and defaults for the boot-time program loader.
package mem_loader_pkg;

    localparam int unsigned DEF_WIDTH      = 8;
    localparam int unsigned DEF_LOAD_WORDS = 64;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_RELEASE = 3'd2,
        ST_RUN     = 3'd3,
        ST_ERROR   = 3'd4
    } state_t;

endpackage : mem_loader_pkg

// File: rtl/mem_wr_mux.sv
// Selects the exmem write port source: the loader's registered write or the live cpu port.
module mem_wr_mux #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             i_sel_cpu,
    input  logic             i_ld_we,
    input  logic [WIDTH-1:0] i_ld_adr,
    input  logic [WIDTH-1:0] i_ld_data,
    input  logic             i_cpu_we,
    input  logic [WIDTH-1:0] i_cpu_adr,
    input  logic [WIDTH-1:0] i_cpu_data,
    output logic             o_we_c,
    output logic [WIDTH-1:0] o_adr_c,
    output logic [WIDTH-1:0] o_data_c
);

    always_comb begin
        o_we_c   = 1'b0;
        o_adr_c  = i_ld_adr;
        o_data_c = i_ld_data;
        if (i_sel_cpu) begin
            o_we_c   = i_cpu_we;
            o_adr_c  = i_cpu_adr;
            o_data_c = i_cpu_data;
        end else if (i_ld_we) begin
            o_we_c = 1'b1;
        end
    end

endmodule : mem_wr_mux

// File: rtl/mem_loader.sv
// Boot loader: holds the mips core in reset, streams LOAD_WORDS host bytes into exmem, then hands over.
// Optional trailing-byte checksum check is enabled with MEM_LOADER_CHECKSUM_EN.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned LOAD_WORDS = DEF_LOAD_WORDS
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] in_data,
    output logic             in_ready,
    input  logic             cpu_memwrite,
    input  logic [WIDTH-1:0] cpu_adr,
    input  logic [WIDTH-1:0] cpu_writedata,
    output logic             mem_memwrite,
    output logic [WIDTH-1:0] mem_adr,
    output logic [WIDTH-1:0] mem_writedata,
    output logic             cpu_reset,
    output logic             done,
    output logic             err
);

    // Pointer is one bit wider so a full 2**WIDTH load can still terminate.
    localparam int unsigned PW = WIDTH + 1;
`ifdef MEM_LOADER_CHECKSUM_EN
    localparam int unsigned N_BYTES = LOAD_WORDS + 1;
`else
    localparam int unsigned N_BYTES = LOAD_WORDS;
`endif
    localparam logic [PW-1:0] WORDS_P = PW'(LOAD_WORDS);
    localparam logic [PW-1:0] BYTES_P = PW'(N_BYTES);
    localparam logic [PW-1:0] LAST_P  = PW'(N_BYTES - 1);

    state_t           r_state;
    state_t           w_next;
    logic [PW-1:0]    r_ptr;
    logic [PW-1:0]    w_ptr_nxt;
    logic             r_wr_pend;
    logic             w_wr_pend_nxt;
    logic [WIDTH-1:0] r_wr_adr;
    logic [WIDTH-1:0] w_wr_adr_nxt;
    logic [WIDTH-1:0] r_wr_data;
    logic [WIDTH-1:0] w_wr_data_nxt;
    logic             r_in_ready;
    logic             w_in_ready_nxt;
    logic             r_cpu_reset;
    logic             r_done;
    logic             r_err;
    logic             w_accept;
`ifdef MEM_LOADER_CHECKSUM_EN
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] w_sum_nxt;
`endif

    assign w_accept = r_in_ready && in_valid;

    // Next-state, pointer and loader write-register logic.
    always_comb begin
        w_next        = r_state;
        w_ptr_nxt     = r_ptr;
        w_wr_pend_nxt = 1'b0;
        w_wr_adr_nxt  = r_wr_adr;
        w_wr_data_nxt = r_wr_data;
`ifdef MEM_LOADER_CHECKSUM_EN
        w_sum_nxt     = r_sum;
`endif
        case (r_state)
            ST_IDLE, ST_RUN, ST_ERROR: begin
                if (start) begin
                    w_next    = ST_LOAD;
                    w_ptr_nxt = '0;
`ifdef MEM_LOADER_CHECKSUM_EN
                    w_sum_nxt = '0;
`endif
                end
            end
            ST_LOAD: begin
                if (w_accept) begin
                    w_ptr_nxt = r_ptr + PW'(1);
                    if (r_ptr < WORDS_P) begin
                        w_wr_pend_nxt = 1'b1;
                        w_wr_adr_nxt  = r_ptr[WIDTH-1:0];
                        w_wr_data_nxt = in_data;
                    end
`ifdef MEM_LOADER_CHECKSUM_EN
                    w_sum_nxt = r_sum + in_data;
                    if (r_ptr == LAST_P) begin
                        w_next = (w_sum_nxt == '0) ? ST_RELEASE : ST_ERROR;
                    end
`else
                    if (r_ptr == LAST_P) begin
                        w_next = ST_RELEASE;
                    end
`endif
                end
            end
            ST_RELEASE: w_next = ST_RUN;
            default:    w_next = ST_IDLE;
        endcase
        w_in_ready_nxt = (w_next == ST_LOAD) && (w_ptr_nxt < BYTES_P);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_ptr       <= '0;
            r_wr_pend   <= 1'b0;
            r_wr_adr    <= '0;
            r_wr_data   <= '0;
            r_in_ready  <= 1'b0;
            r_cpu_reset <= 1'b1;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_ptr       <= w_ptr_nxt;
            r_wr_pend   <= w_wr_pend_nxt;
            r_wr_adr    <= w_wr_adr_nxt;
            r_wr_data   <= w_wr_data_nxt;
            r_in_ready  <= w_in_ready_nxt;
            r_cpu_reset <= (w_next != ST_RUN);
            r_done      <= (w_next == ST_RUN);
            r_err       <= (w_next == ST_ERROR);
        end
    end

`ifdef MEM_LOADER_CHECKSUM_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sum <= '0;
        end else begin
            r_sum <= w_sum_nxt;
        end
    end
`endif

    // The cpu port is only ever selected while done is high, so it is masked whenever cpu_reset is.
    mem_wr_mux #(
        .WIDTH(WIDTH)
    ) u_wr_mux (
        .i_sel_cpu  (r_done),
        .i_ld_we    (r_wr_pend),
        .i_ld_adr   (r_wr_adr),
        .i_ld_data  (r_wr_data),
        .i_cpu_we   (cpu_memwrite),
        .i_cpu_adr  (cpu_adr),
        .i_cpu_data (cpu_writedata),
        .o_we_c     (mem_memwrite),
        .o_adr_c    (mem_adr),
        .o_data_c   (mem_writedata)
    );

    assign in_ready  = r_in_ready;
    assign cpu_reset = r_cpu_reset;
    assign done      = r_done;
    assign err       = r_err;

endmodule : mem_loader

// File: tb/tb_mem_loader.sv
// Self-checking bench for mem_loader with LOAD_WORDS=4; the expected exmem image is kept as a plain array.
module tb_mem_loader;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned LW    = 4;

    logic             clk = 1'b0;
    logic             reset;
    logic             start;
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             in_ready;
    logic             cpu_memwrite;
    logic [WIDTH-1:0] cpu_adr;
    logic [WIDTH-1:0] cpu_writedata;
    logic             mem_memwrite;
    logic [WIDTH-1:0] mem_adr;
    logic [WIDTH-1:0] mem_writedata;
    logic             cpu_reset;
    logic             done;
    logic             err;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem_exp [256];
    logic [7:0] sh_mem  [256];

    mem_loader #(.WIDTH(WIDTH), .LOAD_WORDS(LW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .cpu_memwrite(cpu_memwrite), .cpu_adr(cpu_adr), .cpu_writedata(cpu_writedata),
        .mem_memwrite(mem_memwrite), .mem_adr(mem_adr), .mem_writedata(mem_writedata),
        .cpu_reset(cpu_reset), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Shadow exmem: captures every write the DUT presents, mid-cycle.
    always @(negedge clk) begin
        if (mem_memwrite === 1'b1) sh_mem[mem_adr] = mem_writedata;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One load session; gap_mode 0 = back-to-back, 1 = valid every 3rd cycle, 2 = random gaps.
    task automatic run_load(input logic [7:0] data [LW], input logic [7:0] trail,
                            input int gap_mode, input bit exp_err, input string tag);
        int nb;
        int gap;
        logic [7:0] b;
`ifdef MEM_LOADER_CHECKSUM_EN
        nb = LW + 1;
`else
        nb = LW;
`endif
        start = 1'b1;
        tick();
        start = 1'b0;
        checks++;
        if ({in_ready, cpu_reset, done, err, mem_memwrite} !== 5'b11000) begin
            errors++;
            $display("FAIL %s start_edge rdy/crst/done/err/we got %b exp 11000", tag,
                     {in_ready, cpu_reset, done, err, mem_memwrite});
        end
        for (int k = 0; k < nb; k++) begin
            gap = (gap_mode == 1) ? 2 : (gap_mode == 2) ? int'($urandom_range(0, 2)) : 0;
            for (int g = 0; g < gap; g++) begin
                in_valid = 1'b0;
                tick();
                checks++;
                if ({mem_memwrite, in_ready} !== 2'b01) begin
                    errors++;
                    $display("FAIL %s gap k=%0d we/rdy got %b exp 01", tag, k, {mem_memwrite, in_ready});
                end
            end
            b = (k < LW) ? data[k] : trail;
            checks++;
            if (in_ready !== 1'b1) begin
                errors++;
                $display("FAIL %s ready_before_byte k=%0d got %b exp 1", tag, k, in_ready);
            end
            in_valid = 1'b1;
            in_data  = b;
            tick();
            in_valid = 1'b0;
            in_data  = $urandom();
            checks++;
            if (k < LW) begin
                mem_exp[k] = b;
                if ({mem_memwrite, mem_adr, mem_writedata} !== {1'b1, 8'(k), b}) begin
                    errors++;
                    $display("FAIL %s write k=%0d we/adr/data got %b/%h/%h exp 1/%h/%h", tag, k,
                             mem_memwrite, mem_adr, mem_writedata, 8'(k), b);
                end
            end else if (mem_memwrite !== 1'b0) begin
                errors++;
                $display("FAIL %s trailing_not_written got we=%b exp 0", tag, mem_memwrite);
            end
        end
        if (exp_err) begin
            for (int c = 0; c < 3; c++) begin
                checks++;
                if ({in_ready, cpu_reset, done, err, mem_memwrite} !== 5'b01010) begin
                    errors++;
                    $display("FAIL %s error_state c=%0d got %b exp 01010", tag, c,
                             {in_ready, cpu_reset, done, err, mem_memwrite});
                end
                cpu_memwrite = 1'b0;
                tick();
            end
        end else begin
            checks++;
            if ({in_ready, cpu_reset, done, err} !== 4'b0100) begin
                errors++;
                $display("FAIL %s release rdy/crst/done/err got %b exp 0100", tag,
                         {in_ready, cpu_reset, done, err});
            end
            cpu_memwrite = 1'b0;
            tick();
            checks++;
            if ({in_ready, cpu_reset, done, err, mem_memwrite} !== 5'b00100) begin
                errors++;
                $display("FAIL %s run rdy/crst/done/err/we got %b exp 00100", tag,
                         {in_ready, cpu_reset, done, err, mem_memwrite});
            end
        end
    endtask

    function automatic logic [7:0] neg_sum(input logic [7:0] data [LW]);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < LW; i++) s = s + data[i];
        return 8'(8'h00 - s);
    endfunction

    task automatic test_reset;
        reset = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0;
        cpu_memwrite = 1'b0; cpu_adr = '0; cpu_writedata = '0;
        #12;
        checks++;
        if ({cpu_reset, in_ready, mem_memwrite, done, err} !== 5'b10000) begin
            errors++;
            $display("FAIL reset_asserted got %b exp 10000", {cpu_reset, in_ready, mem_memwrite, done, err});
        end
        reset = 1'b1;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1;
            in_data  = $urandom();
            tick();
            checks++;
            if ({cpu_reset, in_ready, mem_memwrite, done, err} !== 5'b10000) begin
                errors++;
                $display("FAIL idle_hold c=%0d got %b exp 10000", c, {cpu_reset, in_ready, mem_memwrite, done, err});
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_basic;
        logic [7:0] d [LW];
        d = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_load(d, neg_sum(d), 0, 1'b0, "basic");
    endtask

    task automatic test_gaps;
        logic [7:0] d [LW];
        d = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_load(d, neg_sum(d), 1, 1'b0, "gaps");
    endtask

    task automatic test_run_passthrough;
        logic       we;
        logic [7:0] a;
        logic [7:0] wd;
        for (int i = 0; i < 10; i++) begin
            we = (i == 0) ? 1'b1 : 1'($urandom());
            a  = (i == 0) ? 8'h80 : 8'($urandom());
            wd = (i == 0) ? 8'h5A : 8'($urandom());
            cpu_memwrite = we; cpu_adr = a; cpu_writedata = wd;
            #1;
            checks++;
            if ({mem_memwrite, mem_adr, mem_writedata} !== {we, a, wd}) begin
                errors++;
                $display("FAIL passthru i=%0d got %b/%h/%h exp %b/%h/%h", i,
                         mem_memwrite, mem_adr, mem_writedata, we, a, wd);
            end
            if (we) mem_exp[a] = wd;
            tick();
        end
        cpu_memwrite = 1'b0;
    endtask

    // Restart from RUN with the cpu still asserting a write; reload must overwrite address 0.
    task automatic test_restart;
        logic [7:0] d [LW];
        for (int i = 0; i < LW; i++) d[i] = 8'($urandom());
        cpu_memwrite  = 1'b1;
        cpu_adr       = 8'hC0;
        cpu_writedata = 8'($urandom());
        mem_exp[8'hC0] = cpu_writedata;
        run_load(d, neg_sum(d), 2, 1'b0, "restart");
    endtask

    task automatic test_reset_midload;
        logic [7:0] d [2];
        d[0] = 8'($urandom());
        d[1] = 8'($urandom());
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1;
            in_data  = d[k];
            tick();
        end
        in_valid   = 1'b0;
        mem_exp[0] = d[0];
        reset = 1'b0;
        #1;
        checks++;
        if ({cpu_reset, in_ready, mem_memwrite, done, err} !== 5'b10000) begin
            errors++;
            $display("FAIL midload_reset got %b exp 10000", {cpu_reset, in_ready, mem_memwrite, done, err});
        end
        tick();
        reset = 1'b1;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1;
            tick();
            checks++;
            if ({cpu_reset, in_ready, mem_memwrite, done} !== 4'b1000) begin
                errors++;
                $display("FAIL after_midload c=%0d got %b exp 1000", c, {cpu_reset, in_ready, mem_memwrite, done});
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic test_random_loads;
        logic [7:0] d [LW];
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < LW; i++) d[i] = 8'($urandom());
            run_load(d, neg_sum(d), 2, 1'b0, "random");
        end
    endtask

`ifdef MEM_LOADER_CHECKSUM_EN
    task automatic test_checksum;
        logic [7:0] d [LW];
        d = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_load(d, 8'hF7, 0, 1'b1, "cksum_bad");
        run_load(d, 8'hF6, 0, 1'b0, "cksum_good");
    endtask
`endif

    task automatic test_image(input string tag);
        for (int a = 0; a < 256; a++) begin
            checks++;
            if (sh_mem[a] !== mem_exp[a]) begin
                errors++;
                $display("FAIL image_%s adr=%h got %h exp %h", tag, a[7:0], sh_mem[a], mem_exp[a]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_image("basic");
        test_gaps();
        test_image("gaps");
        test_run_passthrough();
        test_restart();
        test_image("restart");
        test_reset_midload();
        test_image("midload");
        test_random_loads();
`ifdef MEM_LOADER_CHECKSUM_EN
        test_checksum();
`endif
        test_image("final");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_mem_loader

// File: doc/mem_loader.md
Name: mem_loader

Overview:
- Boot-time program loader between the byte-stream host link, the mips core and exmem.
- Holds the processor in reset and streams LOAD_WORDS bytes into exmem starting at address 0.
- Then releases the core and passes its memory write port straight through to exmem.
- Upstream feeder of exmem's write port in the mips_mem top level.

Parameters:
WIDTH, 8, data and address width (matches mips/exmem WIDTH)
LOAD_WORDS, 64, bytes loaded per load session; legal range 1..2**WIDTH

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  pulse: begin a load session (honoured in IDLE, RUN, ERROR)
in_valid  in  1  host byte valid
in_data  in  WIDTH  host byte
in_ready  out  1  loader can accept a byte this cycle
cpu_memwrite  in  1  mips write strobe
cpu_adr  in  WIDTH  mips address
cpu_writedata  in  WIDTH  mips write data
mem_memwrite  out  1  to exmem write enable
mem_adr  out  WIDTH  to exmem address
mem_writedata  out  WIDTH  to exmem write data
cpu_reset  out  1  active-high reset to mips core
done  out  1  load complete, core running
err  out  1  checksum failure (tied 0 without macro)

Behaviour:
- States: IDLE, LOAD, RELEASE, RUN, ERROR. Reset (async, reset==0) forces IDLE.
- Reset values: ptr=0, wr_pend=0, cpu_reset=1, done=0, err=0, in_ready=0, mem_memwrite=0.
- IDLE:
  - cpu_reset=1; no memory writes.
  - start -> LOAD, ptr=0.
- LOAD:
  - in_ready=1 while ptr < LOAD_WORDS.
  - Accept on in_valid && in_ready: register byte and address (ptr); ptr++.
  - Write latency 1: a byte accepted at edge N drives mem_memwrite=1, mem_adr=old ptr, mem_writedata=byte for the cycle after N.
  - Back-to-back accepts are legal, one write per cycle. Gaps in in_valid stall with no writes.
  - Last byte accepted (ptr becomes LOAD_WORDS) -> RELEASE; in_ready drops the cycle after the last accept.
- RELEASE:
  - Exactly one cycle, in which the last write lands.
  - cpu_reset stays 1; then -> RUN.
- RUN:
  - cpu_reset=0, done=1.
  - mem_* follows cpu_* combinationally (mux select registered by state).
  - in_ready=0; host bytes are ignored.
- start in RUN:
  - Re-enter LOAD next edge; cpu_reset=1 and done=0 from that edge.
  - cpu_memwrite is masked to 0 from that edge.
- start in LOAD or RELEASE is ignored.
- Address arithmetic: ptr is WIDTH+1 bits so LOAD_WORDS=2**WIDTH terminates; mem_adr uses the low WIDTH bits.
- When cpu_reset=1, mem_memwrite never reflects cpu_memwrite.
- Reset mid-load: immediate IDLE, partial contents in exmem left as is, pending write dropped.

Optional Feature:
- Macro: MEM_LOADER_CHECKSUM_EN.
- Defined:
  - LOAD accepts one extra trailing byte (not written to memory).
  - Running WIDTH-bit sum of all LOAD_WORDS bytes plus the trailing byte is computed, mod 2**WIDTH.
  - Sum==0 -> RELEASE as normal.
  - Otherwise -> ERROR: cpu_reset=1, err=1, done=0, until start (-> LOAD, err cleared) or reset.
- Undefined: no extra byte, no ERROR entry, err=0, sum logic absent.

Decomposition:
- Package mem_loader_pkg:
  - State encoding constants (IDLE=0, LOAD=1, RELEASE=2, RUN=3, ERROR=4; 3 bits).
  - Default WIDTH/LOAD_WORDS.
- One natural sub-module, mem_wr_mux: combinational select between loader write (reg) and cpu_* ports, forcing write=0 when neither is active.
- FSM, pointer and checksum stay in mem_loader.

Test Plan:
- Reset low then high, no start -> cpu_reset=1, in_ready=0, mem_memwrite=0 indefinitely.
- LOAD_WORDS=4, start, bytes 0x11,0x22,0x33,0x44 on consecutive cycles:
  - Writes at adr 0..3 with those data, one cycle after each accept.
  - RELEASE one cycle, then cpu_reset=0 and done=1.
- Same load with in_valid gaps (valid every 3rd cycle) -> identical memory image; no writes in gap cycles.
- In RUN, cpu_memwrite=1, cpu_adr=0x80, cpu_writedata=0x5A -> same cycle mem_memwrite=1, mem_adr=0x80, mem_writedata=0x5A.
- start during RUN -> cpu_reset=1 next edge, done=0, cpu writes masked, reload overwrites adr 0.
- Reset asserted after 2 of 4 bytes -> IDLE immediately, in_ready=0.
- With macro: bytes 0x01,0x02,0x03,0x04 then 0xF6 -> RUN.
- With macro: same bytes, trailing byte 0xF7 -> ERROR, err=1, cpu_reset=1.
